alu_serial: RTL
===============

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start_i, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port src1_i, input, WIDTH, operand A; latched when start is accepted.
REQ-006 SHALL have port src2_i, input, WIDTH, operand B; latched when start is accepted.
REQ-007 SHALL have port ctrl_i, input, 4, operation code {A_invert, B_invert, op[1:0]}; latched when start is accepted.
REQ-008 SHALL have port busy_o, output, 1, high while not in IDLE.
REQ-009 SHALL have port done_o, output, 1, single-cycle completion pulse.
REQ-010 SHALL have port result_o, output, WIDTH, registered result; holds its value until the next done_o.
REQ-011 SHALL have ports zero_o, cout_o and overflow_o, each output, 1, registered flags updated with result_o.

Function
REQ-012 SHALL support these ctrl_i codes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 0111 SLT
- 1100 NOR
Any other code SHALL be computed per the bit-slice rules without error indication.
REQ-013 Bit-slice rules for each bit i:
- a = A[i]^A_invert; b = B[i]^B_invert.
- op 00: a&b. op 01: a|b. op 10: a^b^c. op 11: less (0 except bit 0).
- carry out = majority(a, b, c).
REQ-014 Initial carry-in SHALL equal the latched B_invert.
REQ-015 SHALL use states IDLE, RUN and FIN:
- IDLE -> RUN when start_i=1; operands latched, bit counter cleared.
- RUN processes one bit per cycle, LSB first; RUN -> FIN after bit WIDTH-1.
- FIN -> IDLE unconditionally.
REQ-016 Latency SHALL be fixed: if start is accepted in cycle 0, done_o=1 in cycle WIDTH+1 only (cycle 33 for WIDTH=32), independent of operation.
REQ-017 start_i SHALL be ignored while busy_o=1; operands and ctrl changing during RUN SHALL have no effect.
REQ-018 A start_i asserted in the cycle after FIN (state IDLE) SHALL be accepted, giving a back-to-back throughput of one operation per WIDTH+2 cycles.
REQ-019 For SLT, bit 0 SHALL be written in FIN as (MSB sum bit ^ overflow), giving a correct signed compare; bits 1..WIDTH-1 SHALL be 0.
REQ-020 cout_o SHALL be the carry out of the MSB; overflow_o SHALL be (carry into MSB ^ carry out of MSB) for op 10/11 and 0 otherwise.
REQ-021 zero_o SHALL be 1 iff the final result_o equals 0.
REQ-022 result_o and all flags SHALL update only at the FIN edge, never with partial values.

Reset
REQ-023 rst_n=0 SHALL force state IDLE, counter 0, and busy_o, done_o, result_o, zero_o, cout_o and overflow_o all to 0, asynchronously.
REQ-024 Reset during RUN or FIN SHALL abort the operation with no done_o pulse; the first start after reset release SHALL behave normally.

Configuration
REQ-025 Macro ALU_SERIAL_FLAGS_EN:
- Defined: zero_o, cout_o and overflow_o SHALL be computed as specified.
- Undefined: those three outputs SHALL be tied to 0 and their registers removed; result_o and timing SHALL be unchanged.

Structure
REQ-026 Package alu_serial_pkg SHALL hold the ctrl code constants (AND, OR, ADD, SUB, SLT, NOR) and the state encoding (IDLE, RUN, FIN).
REQ-027 One sub-module SHALL be instantiated: the existing 1-bit slice alu_top_less (inputs src1, src2, less, A_invert, B_invert, cin, operation; outputs result, cout, set). It SHALL be driven each RUN cycle with the current bit, the registered carry, and less=0.

Verification
REQ-028 ADD: 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0, done_o in cycle 33.
REQ-029 SUB: 5 - 5 -> result 0, zero 1, cout 1, overflow 0.
REQ-030 SLT:
- 0xFFFFFFFF vs 0x00000001 -> 0x00000001.
- 0x00000001 vs 0xFFFFFFFF -> 0x00000000.
- 0x80000000 vs 0x7FFFFFFF -> 0x00000001.
REQ-031 NOR: 0x0F0F0F0F, 0x00FF00FF -> 0xF000F000; AND of the same operands -> 0x000F000F.
REQ-032 start_i pulsed with new operands at cycle 10 of a RUN -> ignored, original result returned. rst_n low at cycle 15 -> busy_o=0, result_o=0 immediately, no done_o.
REQ-033 Second start issued in the cycle after done_o -> accepted, second done_o exactly 34 cycles after the first. With ALU_SERIAL_FLAGS_EN undefined -> all flags always 0.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared constants for the bit-serial ALU: ctrl codes, slice op field values, FSM states.
package alu_serial_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_top_less.sv
// One-bit ALU slice: optional operand inversion, AND/OR/SUM/LESS select, full-adder carry.
// Purely combinational; "set" exposes the raw sum bit for signed-compare resolution.
module alu_top_less
  import alu_serial_pkg::*;
(
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout,
  output logic       set
);

  logic a;
  logic b;

  assign a    = src1 ^ A_invert;
  assign b    = src2 ^ B_invert;
  assign set  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

  always_comb begin
    result = 1'b0;
    case (operation)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SUM:  result = set;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU, one bit per cycle LSB first; flags built only with ALU_SERIAL_FLAGS_EN.
// Latency WIDTH+1 cycles from accepted start to done_o; start_i is ignored while busy_o is high.
module alu_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);
  import alu_serial_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [3:0]       ctrl_q;
  logic             carry_q;

  logic             bit_res;
  logic             bit_cout;
  logic             bit_set;
  logic             last_bit;
  logic             msb_ovf;
  logic             fin_edge;
  logic [WIDTH-1:0] final_res;

  alu_top_less u_slice (
    .src1      (a_q[0]),
    .src2      (b_q[0]),
    .less      (1'b0),
    .A_invert  (ctrl_q[3]),
    .B_invert  (ctrl_q[2]),
    .cin       (carry_q),
    .operation (ctrl_q[1:0]),
    .result    (bit_res),
    .cout      (bit_cout),
    .set       (bit_set)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign fin_edge = (state == RUN) && last_bit;
  assign msb_ovf  = carry_q ^ bit_cout;
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == FIN);

  // SLT collapses to a single sign bit corrected by overflow.
  assign final_res = (ctrl_q[1:0] == OP_LESS) ?
                     {{(WIDTH-1){1'b0}}, bit_set ^ msb_ovf} :
                     {bit_res, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      ctrl_q   <= '0;
      carry_q  <= 1'b0;
      result_o <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        a_q     <= src1_i;
        b_q     <= src2_i;
        ctrl_q  <= ctrl_i;
        carry_q <= ctrl_i[2];
        cnt     <= '0;
      end else if (state == RUN) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        acc_q   <= {bit_res, acc_q[WIDTH-1:1]};
        carry_q <= bit_cout;
        cnt     <= cnt + 1'b1;
      end
      if (fin_edge) begin
        result_o <= final_res;
      end
    end
  end

`ifdef ALU_SERIAL_FLAGS_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else if (fin_edge) begin
      zero_o     <= (final_res == '0);
      cout_o     <= bit_cout;
      overflow_o <= ctrl_q[1] & msb_ovf;
    end
  end
`else
  assign zero_o     = 1'b0;
  assign cout_o     = 1'b0;
  assign overflow_o = 1'b0;
`endif

endmodule
